pipeline_sim_monitor: RTL and testbench

Parametrised run controller and PC-trace monitor for the pipeline CPU top (`Main`). It sequences the CPU reset, counts run cycles, and records the most recent distinct `final_address` values in a circular buffer. It declares completion on a PC halt (address stable for a set number of cycles) or on a cycle timeout, and flags pass/fail against an expected halt address. Benches use it as a fixed harness instead of a hand-timed reset and `$stop`.

---
 rtl/pipeline_sim_monitor.sv | 162 ++++++++++++++++
 tb/tb_pipeline_sim_monitor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sim_monitor.sv
// pipeline_sim_monitor
//
// Run controller and PC-trace monitor for the pipeline CPU top. It holds the
// CPU in reset for a fixed number of cycles, then counts run cycles and
// records the most recent distinct final_address values in a circular
// buffer. The run ends on a PC halt (one address repeated STALL_LIMIT times)
// or on a cycle timeout, and pass is raised when the halt address matches
// HALT_ADDR.
//
// Ports:
//   clock          - single clock, rising edge
//   reset          - synchronous, active-high; restarts the whole sequence
//   final_address  - CPU PC/address being monitored
//   trace_rd_idx   - trace read index, 0 is the oldest retained entry
//   cpu_reset      - registered reset driven into the CPU
//   cycle_count    - RUN cycles elapsed (never exceeds MAX_CYCLES)
//   trace_count    - number of valid trace entries, saturates at DEPTH
//   trace_rd_data  - combinational read of entry trace_rd_idx (0 if invalid)
//   done           - sticky, run finished
//   pass           - sticky, halted at HALT_ADDR
//   timeout        - sticky, cycle budget exhausted without a halt

module pipeline_sim_monitor #(
    parameter int                ADDR_W       = 32,
    parameter int                RESET_CYCLES = 2,
    parameter int                MAX_CYCLES   = 50,
    parameter int                STALL_LIMIT  = 4,
    parameter int                DEPTH        = 8,
    parameter logic [ADDR_W-1:0] HALT_ADDR    = 32'h0000_0040
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          final_address,
    input  logic [$clog2(DEPTH)-1:0]   trace_rd_idx,
    output logic                       cpu_reset,
    output logic [31:0]                cycle_count,
    output logic [$clog2(DEPTH):0]     trace_count,
    output logic [ADDR_W-1:0]          trace_rd_data,
    output logic                       done,
    output logic                       pass,
    output logic                       timeout
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int HOLD_W  = $clog2(RESET_CYCLES + 1);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_MAX   = STALL_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0]   COUNT_FULL  = CNT_W'(DEPTH);
    localparam logic [31:0]        CYCLE_LIMIT = 32'(MAX_CYCLES);

    typedef enum logic [1:0] {
        S_RESET_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [STALL_W-1:0]  stall_cnt;
    logic [PTR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]   last_addr;
    logic                first_seen;
    logic [ADDR_W-1:0]   trace_buf [DEPTH];

    logic                is_new;
    logic [31:0]         cycle_next;
    logic [STALL_W-1:0]  stall_next;
    logic                halt_hit;
    logic                timeout_hit;
    logic                buf_we;
    logic [PTR_W-1:0]    rd_ptr;

    // Decisions for the current RUN sample. The very first sample after
    // cpu_reset falls is always recorded, whatever last_addr holds.
    always_comb begin
        is_new      = !first_seen || (final_address != last_addr);
        cycle_next  = cycle_count + 32'd1;
        stall_next  = is_new ? '0 : stall_cnt + STALL_W'(1);
        halt_hit    = !is_new && (stall_next == STALL_MAX);
        timeout_hit = (cycle_next == CYCLE_LIMIT);
        buf_we      = !reset && (state == S_RUN) && is_new;
    end

    // Controller: reset hold, run accounting and sticky status. A halt on
    // the same edge as the timeout takes priority, so timeout stays 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_RESET_HOLD;
            cpu_reset   <= 1'b1;
            hold_cnt    <= '0;
            cycle_count <= '0;
            trace_count <= '0;
            wr_ptr      <= '0;
            stall_cnt   <= '0;
            last_addr   <= '0;
            first_seen  <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                S_RESET_HOLD: begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= S_RUN;
                        cpu_reset <= 1'b0;
                    end
                end
                S_RUN: begin
                    cycle_count <= cycle_next;
                    stall_cnt   <= stall_next;
                    if (is_new) begin
                        wr_ptr     <= wr_ptr + PTR_W'(1);
                        last_addr  <= final_address;
                        first_seen <= 1'b1;
                        if (trace_count != COUNT_FULL) begin
                            trace_count <= trace_count + CNT_W'(1);
                        end
                    end
                    if (halt_hit) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        pass    <= (last_addr == HALT_ADDR);
                        timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                S_DONE: begin
                    cpu_reset <= 1'b0;
                end
                default: begin
                    state <= S_RESET_HOLD;
                end
            endcase
        end
    end

    // Trace storage has no reset; entries beyond trace_count are never read.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            trace_buf[wr_ptr] <= final_address;
        end
    end

    // Index 0 maps to the oldest retained entry; the subtraction wraps
    // naturally in PTR_W bits, including when the buffer is full.
    always_comb begin
        rd_ptr        = wr_ptr - trace_count[PTR_W-1:0] + trace_rd_idx;
        trace_rd_data = '0;
        if ({1'b0, trace_rd_idx} < trace_count) begin
            trace_rd_data = trace_buf[rd_ptr];
        end
    end

endmodule

// File: tb/tb_pipeline_sim_monitor.sv
// tb_pipeline_sim_monitor
//
// Self-checking bench for pipeline_sim_monitor. Each run drives an address
// sequence into final_address and compares the monitor against a reference
// built from the distinct-address history of that sequence.

module tb_pipeline_sim_monitor;

    localparam int          ADDR_W       = 32;
    localparam int          RESET_CYCLES = 2;
    localparam int          MAX_CYCLES   = 50;
    localparam int          STALL_LIMIT  = 4;
    localparam int          DEPTH        = 8;
    localparam logic [31:0] HALT_ADDR    = 32'h0000_0040;

    logic              clock;
    logic              reset;
    logic [ADDR_W-1:0] final_address;
    logic [2:0]        trace_rd_idx;
    logic              cpu_reset;
    logic [31:0]       cycle_count;
    logic [3:0]        trace_count;
    logic [ADDR_W-1:0] trace_rd_data;
    logic              done;
    logic              pass;
    logic              timeout;

    int tests_run;
    int tests_failed;

    logic [31:0] seq [$];

    // Reference results of the most recent completed run
    logic [31:0] ref_hist [$];
    int          ref_end;

    pipeline_sim_monitor #(
        .ADDR_W       (ADDR_W),
        .RESET_CYCLES (RESET_CYCLES),
        .MAX_CYCLES   (MAX_CYCLES),
        .STALL_LIMIT  (STALL_LIMIT),
        .DEPTH        (DEPTH),
        .HALT_ADDR    (HALT_ADDR)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .final_address (final_address),
        .trace_rd_idx  (trace_rd_idx),
        .cpu_reset     (cpu_reset),
        .cycle_count   (cycle_count),
        .trace_count   (trace_count),
        .trace_rd_data (trace_rd_data),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] addrAt(input int n);
        if (n <= seq.size()) return seq[n-1];
        return seq[seq.size()-1];
    endfunction

    // Hold reset, release it and follow cpu_reset through the hold window.
    task automatic doReset(input int hold);
        reset         = 1'b1;
        final_address = '0;
        trace_rd_idx  = '0;
        repeat (hold) begin
            @(posedge clock); #1;
            checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
            checkOutput("rst_cycle_count", cycle_count, 32'd0);
            checkOutput("rst_trace_count", 32'(trace_count), 32'd0);
            checkOutput("rst_status", {29'd0, done, pass, timeout}, 32'd0);
        end
        reset = 1'b0;
        repeat (RESET_CYCLES - 1) begin
            @(posedge clock); #1;
            checkOutput("hold_cpu_reset", 32'(cpu_reset), 32'd1);
        end
        @(posedge clock); #1;
        checkOutput("hold_cpu_reset_fall", 32'(cpu_reset), 32'd0);
        checkOutput("run_cycle_start", cycle_count, 32'd0);
    endtask

    // Drive seq sample by sample and compare against the history model.
    // abort_at > 0 asserts reset once cycle_count reaches that value.
    task automatic applyStimulus(input string name, input int abort_at);
        logic [31:0] last;
        logic [31:0] a;
        int          rep;
        int          k;
        bit          ended;
        bit          exp_pass;
        bit          exp_to;
        ref_hist.delete();
        last     = '0;
        rep      = 0;
        ended    = 1'b0;
        exp_pass = 1'b0;
        exp_to   = 1'b0;
        ref_end  = 0;
        trace_rd_idx = '0;
        for (int n = 1; n <= MAX_CYCLES && !ended; n++) begin
            a = addrAt(n);
            final_address = a;
            @(posedge clock); #1;
            if (n == 1 || a != last) begin
                ref_hist.push_back(a);
                last = a;
                rep  = 0;
            end else begin
                rep++;
            end
            if (rep == STALL_LIMIT) begin
                ended    = 1'b1;
                exp_pass = (last == HALT_ADDR);
            end else if (n == MAX_CYCLES) begin
                ended  = 1'b1;
                exp_to = 1'b1;
            end
            ref_end = n;
            k = (ref_hist.size() < DEPTH) ? ref_hist.size() : DEPTH;
            checkOutput({name, "_cycle"}, cycle_count, 32'(n));
            checkOutput({name, "_tcount"}, 32'(trace_count), 32'(k));
            checkOutput({name, "_oldest"}, trace_rd_data, ref_hist[ref_hist.size()-k]);
            checkOutput({name, "_done"}, 32'(done), 32'(ended));
            checkOutput({name, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
            if (abort_at == n) begin
                reset = 1'b1;
                @(posedge clock); #1;
                checkOutput({name, "_abort_tcount"}, 32'(trace_count), 32'd0);
                checkOutput({name, "_abort_cycle"}, cycle_count, 32'd0);
                checkOutput({name, "_abort_cpu_reset"}, 32'(cpu_reset), 32'd1);
                checkOutput({name, "_abort_done"}, 32'(done), 32'd0);
                return;
            end
        end
        checkOutput({name, "_pass"}, 32'(pass), 32'(exp_pass));
        checkOutput({name, "_timeout"}, 32'(timeout), 32'(exp_to));
        k = (ref_hist.size() < DEPTH) ? ref_hist.size() : DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            trace_rd_idx = 3'(i);
            #1;
            checkOutput({name, "_trace"}, trace_rd_data,
                        (i < k) ? ref_hist[ref_hist.size()-k+i] : 32'd0);
        end
        // Everything must stay frozen in DONE whatever the CPU does.
        trace_rd_idx = '0;
        repeat (10) begin
            final_address = $urandom;
            @(posedge clock); #1;
            checkOutput({name, "_frz_cycle"}, cycle_count, 32'(ref_end));
            checkOutput({name, "_frz_tcount"}, 32'(trace_count), 32'(k));
            checkOutput({name, "_frz_status"}, {29'd0, done, pass, timeout},
                        {29'd0, 1'b1, exp_pass, exp_to});
            checkOutput({name, "_frz_oldest"}, trace_rd_data, ref_hist[ref_hist.size()-k]);
            checkOutput({name, "_frz_cpu_reset"}, 32'(cpu_reset), 32'd0);
        end
    endtask

    task automatic readIdx(input string tag, input int idx, input logic [31:0] expected);
        trace_rd_idx = 3'(idx);
        #1;
        checkOutput(tag, trace_rd_data, expected);
    endtask

    task automatic normalSeq();
        seq.delete();
        for (int i = 0; i <= 16; i++) seq.push_back(32'(i * 4));
    endtask

    task automatic normalDirected();
        checkOutput("normal_cycle21", cycle_count, 32'd21);
        checkOutput("normal_tcount8", 32'(trace_count), 32'd8);
        checkOutput("normal_pass", 32'(pass), 32'd1);
        checkOutput("normal_timeout", 32'(timeout), 32'd0);
        readIdx("normal_idx0", 0, 32'h24);
        readIdx("normal_idx7", 7, 32'h40);
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset         = 1'b1;
        final_address = '0;
        trace_rd_idx  = '0;

        // Normal halt at the expected address
        doReset(3);
        normalSeq();
        applyStimulus("normal", 0);
        normalDirected();

        // Halt at the wrong address straight away
        doReset(3);
        seq.delete();
        seq.push_back(32'h10);
        applyStimulus("wrong", 0);
        checkOutput("wrong_cycle5", cycle_count, 32'd5);
        checkOutput("wrong_pass", 32'(pass), 32'd0);
        readIdx("wrong_idx0", 0, 32'h10);
        readIdx("wrong_idx1", 1, 32'h0);

        // PC never halts
        doReset(3);
        seq.delete();
        for (int i = 0; i < 60; i++) seq.push_back(32'(i * 4));
        applyStimulus("timeout", 0);
        checkOutput("timeout_flag", 32'(timeout), 32'd1);
        checkOutput("timeout_cycle50", cycle_count, 32'd50);

        // Halt and timeout on the same edge
        doReset(3);
        seq.delete();
        for (int i = 0; i < 45; i++) seq.push_back(32'h100 + 32'(i * 4));
        seq.push_back(HALT_ADDR);
        applyStimulus("simul", 0);
        checkOutput("simul_pass", 32'(pass), 32'd1);
        checkOutput("simul_timeout", 32'(timeout), 32'd0);
        checkOutput("simul_cycle50", cycle_count, 32'd50);

        // Reset in the middle of a run, then a full normal run
        doReset(3);
        normalSeq();
        applyStimulus("midrun", 20);
        doReset(2);
        applyStimulus("rerun", 0);
        normalDirected();

        // Reset while in DONE, then randomized address streams
        for (int r = 0; r < 8; r++) begin
            logic [31:0] a;
            int          len;
            doReset(1 + $urandom_range(0, 2));
            seq.delete();
            while (seq.size() < 70) begin
                a   = ($urandom_range(0, 3) == 0) ? HALT_ADDR : 32'($urandom_range(0, 15) * 4);
                len = $urandom_range(1, STALL_LIMIT + 2);
                if (r < 3) len = $urandom_range(1, STALL_LIMIT);
                for (int j = 0; j < len; j++) seq.push_back(a);
            end
            applyStimulus($sformatf("rand%0d", r), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
